// File: rtl/mire_writer.sv
// mire_writer: Wishbone master that fills the HDISP x VDISP frame buffer with a grid test pattern.
// Define MIRE_ANIM_EN to scroll the vertical grid lines by one pixel per frame.
module mire_writer #(
  parameter int unsigned HDISP = 800,
  parameter int unsigned VDISP = 480,
  parameter int unsigned BURST = 64
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        en,
  output logic        wshb_cyc,
  output logic        wshb_stb,
  output logic        wshb_we,
  output logic [3:0]  wshb_sel,
  output logic [31:0] wshb_adr,
  output logic [31:0] wshb_dat_ms,
  output logic [2:0]  wshb_cti,
  output logic [1:0]  wshb_bte,
  input  logic        wshb_ack,
  input  logic        wshb_err,
  input  logic        wshb_rty,
  output logic        frame_done,
  output logic        bus_err
);

  localparam int unsigned XW = $clog2(HDISP);
  localparam int unsigned YW = $clog2(VDISP);
  localparam int unsigned SW = $clog2(BURST + 1);

  typedef enum logic [1:0] {IDLE, WRITE, PAUSE} state_t;

  state_t        state, next_state;
  logic [XW-1:0] x, nx;
  logic [YW-1:0] y, ny;
  logic [SW-1:0] sess;
  logic          retire, frame_end, burst_end, load;
  logic [3:0]    cur_off, nxt_off;

  function automatic logic [31:0] pix_adr(logic [XW-1:0] px, logic [YW-1:0] py);
    return (32'(py) * HDISP + 32'(px)) << 2;
  endfunction

  function automatic logic [31:0] pix_dat(logic [XW-1:0] px, logic [YW-1:0] py, logic [3:0] off);
    logic [3:0] xl;
    xl = 4'(px) + off;
    return ((xl == 4'd0) || (4'(py) == 4'd0)) ? 32'h00FF_FFFF : 32'h0000_0000;
  endfunction

  // Classic single writes: only cyc/stb vary, the rest of the bus is constant.
  assign wshb_cyc = (state == WRITE);
  assign wshb_stb = (state == WRITE);
  assign wshb_we  = 1'b1;
  assign wshb_sel = 4'hF;
  assign wshb_cti = 3'b000;
  assign wshb_bte = 2'b00;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    frame_end = (x == XW'(HDISP - 1)) && (y == YW'(VDISP - 1));
    burst_end = (sess == SW'(BURST - 1));
    nx        = x + XW'(1);
    ny        = y;
    if (x == XW'(HDISP - 1)) begin
      nx = '0;
      ny = (y == YW'(VDISP - 1)) ? '0 : y + YW'(1);
    end
  end

  always_comb begin
    next_state = state;
    retire     = 1'b0;
    case (state)
      IDLE:  if (en) next_state = WRITE;
      WRITE: begin
        // err retires like ack; rty alone leaves the strobe untouched.
        if (wshb_err || wshb_ack) begin
          retire = 1'b1;
          if (!en)            next_state = IDLE;
          else if (burst_end) next_state = PAUSE;
        end
      end
      PAUSE:   next_state = en ? WRITE : IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign load = (state != WRITE) && (next_state == WRITE);

`ifdef MIRE_ANIM_EN
  logic [7:0] offset;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)                    offset <= 8'd0;
    else if (retire && frame_end)   offset <= offset + 8'd1;
  end

  // The first pixel of a new frame already uses the advanced offset.
  assign cur_off = offset[3:0];
  assign nxt_off = offset[3:0] + 4'(retire && frame_end);
`else
  assign cur_off = 4'd0;
  assign nxt_off = 4'd0;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= next_state;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values of its neighbours.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      x           <= '0;
      y           <= '0;
      sess        <= '0;
      wshb_adr    <= '0;
      wshb_dat_ms <= '0;
      frame_done  <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      frame_done <= retire && frame_end;
      if (retire && wshb_err) bus_err <= 1'b1;
      if (retire) begin
        x           <= nx;
        y           <= ny;
        wshb_adr    <= pix_adr(nx, ny);
        wshb_dat_ms <= pix_dat(nx, ny, nxt_off);
        sess        <= (next_state == WRITE) ? sess + SW'(1) : '0;
      end else if (load) begin
        // Resuming from IDLE/PAUSE: present the pixel where writing stopped.
        wshb_adr    <= pix_adr(x, y);
        wshb_dat_ms <= pix_dat(x, y, cur_off);
      end
    end
  end

endmodule

// File: tb/tb_mire_writer.sv
// Scoreboard bench for mire_writer: a randomised Wishbone slave pushes expected pixels,
// a monitor pops and compares them together with cyc timing, frame_done and bus_err.
`timescale 1ns/1ps
module tb_mire_writer;

  localparam int H    = 32;
  localparam int V    = 4;
  localparam int B    = 8;
  localparam int NPIX = H * V;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        en      = 1'b0;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack = 1'b0, err = 1'b0, rty = 1'b0;
  logic        frame_done, bus_err;

  mire_writer #(.HDISP(H), .VDISP(V), .BURST(B)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en),
    .wshb_cyc(cyc), .wshb_stb(stb), .wshb_we(we), .wshb_sel(sel),
    .wshb_adr(adr), .wshb_dat_ms(dat), .wshb_cti(cti), .wshb_bte(bte),
    .wshb_ack(ack), .wshb_err(err), .wshb_rty(rty),
    .frame_done(frame_done), .bus_err(bus_err)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef enum {K_ACK, K_RTY, K_ERR} kind_t;
  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    kind_t       kind;
    bit          last;
  } exp_t;

  exp_t sb_q[$];

  // Reference picture: pixel p of frame f, straight from the grid rule.
  function automatic logic [31:0] model_dat(int p, int f);
    int px, py, off;
    px  = p % H;
    py  = p / H;
    off = 0;
`ifdef MIRE_ANIM_EN
    off = f % 256;
`endif
    return ((((px + off) % 16) == 0) || ((py % 16) == 0)) ? 32'h00FF_FFFF : 32'h0;
  endfunction

  // Slave configuration, changed by the stimulus process.
  int          min_delay = 0, max_delay = 0, err_pct = 0, rty_pct = 0;
  logic [31:0] inj_err_adr = 32'h8;
  bit          inj_err_done = 1'b0;
  logic [31:0] inj_rty_adr = 32'h10;
  int          inj_rty_left = 2;

  initial begin : slave
    int    p, f, wcnt, dly, r;
    kind_t k;
    exp_t  e;
    p = 0; f = 0; wcnt = 0; dly = 0;
    forever begin
      @(posedge sys_clk);
      #1;
      ack = 1'b0; err = 1'b0; rty = 1'b0;
      if (sys_rst) begin
        p = 0; f = 0; wcnt = 0;
        sb_q.delete();
      end else if (cyc && stb) begin
        if (wcnt < dly) wcnt++;
        else begin
          r = $urandom_range(0, 99);
          if (adr == inj_err_adr && !inj_err_done) begin
            k = K_ERR; inj_err_done = 1'b1;
          end else if (adr == inj_rty_adr && inj_rty_left > 0) begin
            k = K_RTY; inj_rty_left--;
          end else if (r < err_pct)           k = K_ERR;
          else if (r < err_pct + rty_pct)     k = K_RTY;
          else                                k = K_ACK;
          // Lower-priority responses are sometimes raised alongside to exercise priority.
          case (k)
            K_ERR:   begin err = 1'b1; ack = 1'($urandom_range(0, 1)); rty = 1'($urandom_range(0, 1)); end
            K_ACK:   begin ack = 1'b1; rty = 1'($urandom_range(0, 1)); end
            default: rty = 1'b1;
          endcase
          e.adr  = 32'(p * 4);
          e.dat  = model_dat(p, f);
          e.kind = k;
          e.last = (p == NPIX - 1);
          sb_q.push_back(e);
          if (k != K_RTY) begin
            p++;
            if (p == NPIX) begin p = 0; f++; end
          end
          wcnt = 0;
          dly  = $urandom_range(min_delay, max_delay);
        end
      end else begin
        wcnt = 0;
        dly  = $urandom_range(min_delay, max_delay);
      end
    end
  end

  initial begin : monitor
    exp_t e;
    bit   fd_exp, berr_exp, prev_cyc, prev_en, prev_ret, ret_en, exp_cyc;
    int   sess;
    fd_exp = 0; berr_exp = 0; prev_cyc = 0; prev_en = 0; prev_ret = 0; ret_en = 0; sess = 0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        fd_exp = 0; berr_exp = 0; prev_cyc = 0; prev_en = 0; prev_ret = 0; sess = 0;
      end else begin
        check("frame_done", frame_done, fd_exp);
        check("bus_err", bus_err, berr_exp);
        check("stb_vs_cyc", stb, cyc);
        // cyc may drop only after a retirement that ends a session or sees en=0,
        // and must return the cycle after en is seen high while released.
        if (prev_cyc) exp_cyc = prev_ret ? !((sess == B) || !ret_en) : 1'b1;
        else          exp_cyc = prev_en;
        check("cyc", cyc, exp_cyc);
        if (prev_cyc && !cyc) sess = 0;
        fd_exp   = 0;
        prev_ret = 0;
        if (cyc && stb && (ack || err || rty)) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: response seen with no expected pixel, adr %h", adr);
          end else begin
            e = sb_q.pop_front();
            check("adr", adr, e.adr);
            check("dat", dat, e.dat);
            if (e.kind != K_RTY) begin
              sess++;
              prev_ret = 1;
              ret_en   = en;
              if (e.last)         fd_exp   = 1;
              if (e.kind == K_ERR) berr_exp = 1;
            end
          end
        end
        prev_cyc = cyc;
        prev_en  = en;
      end
    end
  end

  task automatic wait_cyc(bit v, int budget, string name);
    for (int n = 0; n < budget; n++) begin
      @(negedge sys_clk);
      if (cyc == v) return;
    end
    checks++; errors++;
    $display("FAIL %s: cyc is %0b after %0d cycles, wanted %0b", name, cyc, budget, v);
  endtask

  task automatic reset_checks(string tag);
    check({tag, "_cyc"}, cyc, 0);
    check({tag, "_stb"}, stb, 0);
    check({tag, "_adr"}, adr, 0);
    check({tag, "_dat"}, dat, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_bus_err"}, bus_err, 0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    // Ack every cycle, with err injected on 0x008 and two retries on 0x010.
    repeat (2) @(posedge sys_clk);
    #1;
    reset_checks("reset");
    check("reset_we", we, 1);
    check("reset_sel", sel, 4'hF);
    check("reset_cti", cti, 0);
    check("reset_bte", bte, 0);
    @(posedge sys_clk);
    #2 sys_rst = 1'b0; en = 1'b1;
    repeat (400) @(posedge sys_clk);

    // Random delays, retries, errors and en toggling.
    max_delay = 3; err_pct = 3; rty_pct = 12;
    repeat (3000) begin
      @(posedge sys_clk);
      #2;
      if ($urandom_range(0, 39) == 0) en = ~en;
    end

    // en falls while a 5-cycle-delayed strobe is pending.
    err_pct = 0; rty_pct = 0;
    @(posedge sys_clk); #2 en = 1'b0;
    wait_cyc(0, 200, "drain_to_idle");
    min_delay = 5; max_delay = 5;
    repeat (3) @(posedge sys_clk);
    #2 en = 1'b1;
    wait_cyc(1, 20, "start_write");
    @(posedge sys_clk); #2 en = 1'b0;
    wait_cyc(0, 50, "idle_after_ack");
    repeat (10) @(posedge sys_clk);
    #2 en = 1'b1;
    repeat (100) @(posedge sys_clk);

    // Asynchronous reset in the middle of a strobe.
    min_delay = 0; max_delay = 2;
    wait_cyc(1, 50, "strobe_before_reset");
    @(posedge sys_clk);
    #3 sys_rst = 1'b1;
    #1;
    reset_checks("async_reset");
    repeat (2) @(posedge sys_clk);
    #2 sys_rst = 1'b0;
    repeat (300) @(posedge sys_clk);

    #2 en = 1'b0;
    wait_cyc(0, 50, "final_idle");
    repeat (5) @(posedge sys_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
